seq_div_32: RTL and testbench

//  Multi-cycle signed integer divider: the inverse of the datapath's 32x32 Booth multiplier.

---
 rtl/seq_div_32_if.sv | 15 +
 rtl/seq_div_32.sv | 134 +++++++++++++
 tb/tb_seq_div_32.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/seq_div_32_if.sv
// Handshake and result bundle for the sequential signed divider.
interface seq_div_32_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic               div_zero;
  logic [2*WIDTH-1:0] z;

  modport master (output start, a, b, input busy, done, div_zero, z);
  modport slave  (input start, a, b, output busy, done, div_zero, z);
endinterface

// File: rtl/seq_div_32.sv
// Multi-cycle signed divider, non-restoring radix-2, one quotient bit per clock.
// z = {remainder, quotient}; remainder takes the dividend's sign.
module seq_div_32 #(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         clear,
  seq_div_32_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, RUN, FIX, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [WIDTH:0]       abs_b_q, abs_b_d;
  logic [WIDTH:0]       r_q, r_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sign_q_q, sign_q_d, sign_r_q, sign_r_d;
  logic                 zero_q, zero_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 div_zero_q, div_zero_d;
  logic [2*WIDTH-1:0]   z_q, z_d;

  logic [WIDTH:0]       r_sh, r_step;
  logic [WIDTH-1:0]     abs_a, r_fix, r_out, q_out;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    abs_b_d    = abs_b_q;
    r_d        = r_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    sign_q_d   = sign_q_q;
    sign_r_d   = sign_r_q;
    zero_d     = zero_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    z_d        = z_q;

    // |a| as an unsigned WIDTH-bit value keeps 2^(WIDTH-1) intact
    abs_a  = a_q[WIDTH-1] ? (WIDTH'(0) - a_q) : a_q;
    r_sh   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    r_step = r_q[WIDTH] ? (r_sh + abs_b_q) : (r_sh - abs_b_q);
    r_fix  = r_q[WIDTH] ? (r_q[WIDTH-1:0] + abs_b_q[WIDTH-1:0]) : r_q[WIDTH-1:0];
    r_out  = sign_r_q ? (WIDTH'(0) - r_fix) : r_fix;
    q_out  = sign_q_q ? (WIDTH'(0) - q_q) : q_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        sign_q_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        sign_r_d = a_q[WIDTH-1];
        abs_b_d  = b_q[WIDTH-1] ? ((WIDTH+1)'(0) - {1'b1, b_q}) : {1'b0, b_q};
        r_d      = '0;
        q_d      = abs_a;
        cnt_d    = '0;
        // divide-by-zero still passes through FIX so the result is registered in one place
        zero_d   = (b_q == '0);
        state_d  = (b_q == '0) ? FIX : RUN;
      end
      RUN: begin
        r_d   = r_step;
        q_d   = {q_q[WIDTH-2:0], ~r_step[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (zero_q) begin
          z_d        = {a_q, {WIDTH{1'b1}}};
          div_zero_d = 1'b1;
        end else begin
          z_d        = {r_out, q_out};
          div_zero_d = 1'b0;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      abs_b_q    <= '0;
      r_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      zero_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      z_q        <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      abs_b_q    <= abs_b_d;
      r_q        <= r_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      sign_q_q   <= sign_q_d;
      sign_r_q   <= sign_r_d;
      zero_q     <= zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      z_q        <= z_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.z        = z_q;
endmodule

// File: tb/tb_seq_div_32.sv
// Directed and randomised checks for seq_div_32.
module tb_seq_div_32;
  logic clock;
  logic clear;
  int   passed;
  int   total;

  seq_div_32_if #(.WIDTH(32)) bus ();
  seq_div_32 #(.WIDTH(32)) dut (.clock(clock), .clear(clear), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Launches one operation and waits (bounded) for done; returns result, latency and hold status.
  task automatic do_op(input logic [31:0] aa, input logic [31:0] bb,
                       output logic [63:0] zz, output logic dzo, output int lat,
                       output bit stable);
    logic [63:0] z0;
    logic        dz0;
    if (bus.done) begin
      @(posedge clock); #1;
    end
    z0 = bus.z; dz0 = bus.div_zero;
    stable = 1'b1;
    @(negedge clock);
    bus.start = 1'b1; bus.a = aa; bus.b = bb;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.z !== z0 || bus.div_zero !== dz0) stable = 1'b0;
    end
    zz = bus.z; dzo = bus.div_zero;
  endtask

  task automatic test_reset;
    clear = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000 || bus.z !== 64'd0)
      $display("FAIL reset: busy=%b done=%b dz=%b z=%h, required 0/0/0/0",
               bus.busy, bus.done, bus.div_zero, bus.z);
    else passed++;
    @(negedge clock); clear = 1'b0;
  endtask

  task automatic test_basic;
    logic [63:0] zz; logic dz; int lat; bit st;
    do_op(32'd7, 32'd2, zz, dz, lat, st);
    total++;
    if (lat !== 34) $display("FAIL basic_latency: got %0d required 34", lat);
    else passed++;
    total++;
    if (zz !== {32'd1, 32'd3} || dz !== 1'b0)
      $display("FAIL basic_7div2: z=%h dz=%b required %h dz=0", zz, dz, {32'd1, 32'd3});
    else passed++;
  endtask

  task automatic test_signs;
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [63:0] ve [6];
    logic [63:0] zz; logic dz; int lat; bit st;
    va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2;        ve[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    va[1] = 32'd7;         vb[1] = 32'hFFFF_FFFE; ve[1] = {32'd1, 32'hFFFF_FFFD};
    va[2] = 32'hFFFF_FFF9; vb[2] = 32'hFFFF_FFFE; ve[2] = {32'hFFFF_FFFF, 32'd3};
    va[3] = 32'h8000_0000; vb[3] = 32'hFFFF_FFFF; ve[3] = {32'd0, 32'h8000_0000};
    va[4] = 32'h8000_0000; vb[4] = 32'd1;        ve[4] = {32'd0, 32'h8000_0000};
    va[5] = 32'd5;         vb[5] = 32'd7;        ve[5] = {32'd5, 32'd0};
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], zz, dz, lat, st);
      total++;
      if (zz !== ve[i] || dz !== 1'b0 || lat !== 34)
        $display("FAIL vector%0d %h/%h: z=%h dz=%b lat=%0d required z=%h dz=0 lat=34",
                 i, va[i], vb[i], zz, dz, lat, ve[i]);
      else passed++;
    end
  endtask

  task automatic test_div_zero;
    logic [63:0] zz; logic dz; int lat; bit st;
    do_op(32'd123, 32'd0, zz, dz, lat, st);
    total++;
    if (lat !== 2) $display("FAIL divzero_latency: got %0d required 2", lat);
    else passed++;
    total++;
    if (zz !== {32'd123, 32'hFFFF_FFFF} || dz !== 1'b1)
      $display("FAIL divzero_result: z=%h dz=%b required %h dz=1",
               zz, dz, {32'd123, 32'hFFFF_FFFF});
    else passed++;
    do_op(32'd100, 32'd10, zz, dz, lat, st);
    total++;
    if (zz !== {32'd0, 32'd10} || dz !== 1'b0)
      $display("FAIL divzero_cleared: z=%h dz=%b required %h dz=0", zz, dz, {32'd0, 32'd10});
    else passed++;
  endtask

  task automatic test_handshake;
    logic [63:0] zz; logic dz; int lat; bit st; bit seen;
    if (bus.done) begin @(posedge clock); #1; end
    @(negedge clock); bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clock); #1; bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) $display("FAIL busy_after_start: got %b required 1", bus.busy);
    else passed++;
    repeat (9) @(posedge clock);
    @(negedge clock); bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd1;
    @(posedge clock); #1; bus.start = 1'b0;
    lat = 0;
    for (int i = 11; i <= 100; i++) begin
      @(posedge clock); #1;
      if (bus.done) begin lat = i; break; end
    end
    total++;
    if (lat !== 34 || bus.z !== {32'd2, 32'd14})
      $display("FAIL restart_ignored: lat=%0d z=%h required lat=34 z=%h",
               lat, bus.z, {32'd2, 32'd14});
    else passed++;

    @(posedge clock); #1;
    @(negedge clock); bus.start = 1'b1; bus.a = 32'd1000; bus.b = 32'd3;
    @(posedge clock); #1; bus.start = 1'b0;
    repeat (14) @(posedge clock);
    @(negedge clock); clear = 1'b1;
    @(posedge clock); #1;
    total++;
    if (bus.busy !== 1'b0 || bus.z !== 64'd0 || bus.done !== 1'b0)
      $display("FAIL clear_midop: busy=%b done=%b z=%h required 0/0/0", bus.busy, bus.done, bus.z);
    else passed++;
    @(negedge clock); clear = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.done) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL no_done_after_clear: done seen=%b required 0", seen);
    else passed++;
    do_op(32'd1000, 32'd3, zz, dz, lat, st);
    total++;
    if (zz !== {32'd1, 32'd333} || lat !== 34)
      $display("FAIL fresh_op: z=%h lat=%0d required %h lat=34", zz, lat, {32'd1, 32'd333});
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [63:0] zz; logic dz; int lat; bit st;
    logic [31:0] ra, rb;
    longint sa, sb, mq, mr;
    logic [63:0] exp;
    for (int n = 0; n < 200; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 4 == 1) rb = $urandom_range(1, 20);
      if (n % 4 == 2) rb = -$urandom_range(1, 20);
      if (rb == 32'd0) rb = 32'd3;
      sa = longint'($signed(ra));
      sb = longint'($signed(rb));
      mq = sa / sb;
      mr = sa % sb;
      exp = {mr[31:0], mq[31:0]};
      do_op(ra, rb, zz, dz, lat, st);
      total++;
      if (zz !== exp || dz !== 1'b0 || lat !== 34)
        $display("FAIL random%0d %h/%h: z=%h dz=%b lat=%0d required z=%h dz=0 lat=34",
                 n, ra, rb, zz, dz, lat, exp);
      else passed++;
      total++;
      if (st !== 1'b1) $display("FAIL hold%0d: z changed while busy, stable=%b required 1", n, st);
      else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_handshake();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
